// File: rtl/wrsw_pstats_pkg.sv
// Shared definitions for the pstats scanner: slave register map, command encodings
// and the FSM state types used by the scanner and its bus engine.
package wrsw_pstats_pkg;

    localparam logic [3:0]  REG_CR    = 4'h0;
    localparam logic [3:0]  REG_DATA  = 4'h4;
    localparam logic [7:0]  CR_RD_OP  = 8'h01;
    localparam logic [31:0] CMD_CLEAR = 32'h8000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CR_REQ,
        ST_CR_ACK,
        ST_RD_REQ,
        ST_RD_ACK,
        ST_EMIT,
        ST_CLR_REQ,
        ST_CLR_ACK
    } scan_state_t;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_STB,
        WB_WAIT
    } wb_phase_t;

    // CR layout: [31:24] reserved, [23:16] word, [15:8] port, [7:0] opcode
    function automatic logic [31:0] cr_read_cmd(input logic [7:0] port, input logic [7:0] word);
        return {8'h00, word, port, CR_RD_OP};
    endfunction

endpackage

// File: rtl/wrsw_pstats_wb_access.sv
// Single-transfer pipelined Wishbone master: one request in, one done/timeout pulse out.
// The timeout counter runs for every cycle the transfer is in flight (strobe or ack wait).
module wrsw_pstats_wb_access
    import wrsw_pstats_pkg::*;
#(
    parameter int unsigned g_timeout = 255
)(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  adr_i,
    input  logic [31:0] dat_i,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        timeout_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_stall_i
);

    localparam int unsigned c_tw = (g_timeout > 1) ? $clog2(g_timeout) : 1;
    localparam logic [c_tw-1:0] c_tmo_last = c_tw'(g_timeout - 1);

    wb_phase_t       r_phase;
    logic [c_tw-1:0] r_tmo;
    logic            r_cyc, r_stb, r_we, r_done, r_timeout;
    logic [3:0]      r_adr;
    logic [31:0]     r_dat, r_rdata;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_phase   <= WB_IDLE;
            r_tmo     <= '0;
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_rdata   <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            case (r_phase)
                WB_IDLE: begin
                    if (req_i) begin
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_we    <= we_i;
                        r_adr   <= adr_i;
                        r_dat   <= dat_i;
                        r_tmo   <= '0;
                        r_phase <= WB_STB;
                    end
                end
                default: begin
                    if (r_tmo == c_tmo_last) begin
                        r_cyc     <= 1'b0;
                        r_stb     <= 1'b0;
                        r_we      <= 1'b0;
                        r_timeout <= 1'b1;
                        r_phase   <= WB_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                        if (r_phase == WB_STB) begin
                            if (!wb_stall_i) begin
                                r_stb   <= 1'b0;
                                r_phase <= WB_WAIT;
                            end
                        end else if (wb_ack_i) begin
                            r_cyc   <= 1'b0;
                            r_we    <= 1'b0;
                            r_rdata <= wb_dat_i;
                            r_done  <= 1'b1;
                            r_phase <= WB_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign done_o    = r_done;
    assign rdata_o   = r_rdata;
    assign timeout_o = r_timeout;
    assign wb_cyc_o  = r_cyc;
    assign wb_stb_o  = r_stb;
    assign wb_we_o   = r_we;
    assign wb_adr_o  = r_adr;
    assign wb_dat_o  = r_dat;

endmodule

// File: rtl/wrsw_pstats_scanner.sv
// Walks every (port, word) of the pstats counter block: CR read command, DATA read,
// then presents the word on a valid/ready stream. Also issues the global clear command.
module wrsw_pstats_scanner
    import wrsw_pstats_pkg::*;
#(
    parameter int unsigned g_nports  = 8,
    parameter int unsigned g_cnt_pp  = 17,
    parameter int unsigned g_cnt_pw  = 4,
    parameter int unsigned g_timeout = 255
)(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        clear_i,
    output logic [3:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_ack_i,
    input  logic        wb_stall_i,
    output logic [31:0] cnt_dat_o,
    output logic [7:0]  cnt_port_o,
    output logic [7:0]  cnt_word_o,
    output logic        cnt_valid_o,
    input  logic        cnt_ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int unsigned c_words     = (g_cnt_pp + g_cnt_pw - 1) / g_cnt_pw;
    localparam logic [7:0]  c_last_word = 8'(c_words - 1);
    localparam logic [7:0]  c_last_port = 8'(g_nports - 1);

    scan_state_t r_state;
    logic [7:0]  r_port, r_word;
    logic [31:0] r_cnt_dat;
    logic        r_valid, r_done, r_err;

    logic        w_req, w_we, w_acc_done, w_acc_tmo, w_cyc, w_stb, w_accept;
    logic [3:0]  w_adr;
    logic [31:0] w_dat, w_rdata;

    // A new transfer is only requested once the engine has dropped cyc, which
    // guarantees the idle bus cycle between the CR write and the DATA read.
    always_comb begin
        w_we  = 1'b0;
        w_adr = REG_CR;
        w_dat = '0;
        case (r_state)
            ST_CR_REQ:  begin w_we = 1'b1; w_dat = cr_read_cmd(r_port, r_word); end
            ST_RD_REQ:  w_adr = REG_DATA;
            ST_CLR_REQ: begin w_we = 1'b1; w_dat = CMD_CLEAR; end
            default:    ;
        endcase
        w_req = (r_state == ST_CR_REQ || r_state == ST_RD_REQ || r_state == ST_CLR_REQ)
                && !w_cyc && !w_acc_tmo;
    end

    assign w_accept = w_stb && !wb_stall_i;

    wrsw_pstats_wb_access #(
        .g_timeout (g_timeout)
    ) u_wb_access (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (w_req),
        .we_i       (w_we),
        .adr_i      (w_adr),
        .dat_i      (w_dat),
        .done_o     (w_acc_done),
        .rdata_o    (w_rdata),
        .timeout_o  (w_acc_tmo),
        .wb_cyc_o   (w_cyc),
        .wb_stb_o   (w_stb),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .wb_stall_i (wb_stall_i)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_port    <= '0;
            r_word    <= '0;
            r_cnt_dat <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_acc_tmo) begin
                r_state <= ST_IDLE;
                r_err   <= 1'b1;
                r_done  <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (clear_i) begin
                            r_err   <= 1'b0;
                            r_state <= ST_CLR_REQ;
                        end else if (start_i) begin
                            r_err   <= 1'b0;
                            r_port  <= '0;
                            r_word  <= '0;
                            r_state <= ST_CR_REQ;
                        end
                    end
                    ST_CR_REQ:  if (w_accept) r_state <= ST_CR_ACK;
                    ST_CR_ACK:  if (w_acc_done) r_state <= ST_RD_REQ;
                    ST_RD_REQ:  if (w_accept) r_state <= ST_RD_ACK;
                    ST_RD_ACK: begin
                        if (w_acc_done) begin
                            r_cnt_dat <= w_rdata;
                            r_valid   <= 1'b1;
                            r_state   <= ST_EMIT;
                        end
                    end
                    ST_CLR_REQ: if (w_accept) r_state <= ST_CLR_ACK;
                    ST_CLR_ACK: begin
                        if (w_acc_done) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_EMIT: begin
                        if (cnt_ready_i) begin
                            r_valid <= 1'b0;
                            if (r_word != c_last_word) begin
                                r_word  <= r_word + 8'd1;
                                r_state <= ST_CR_REQ;
                            end else if (r_port != c_last_port) begin
                                r_word  <= '0;
                                r_port  <= r_port + 8'd1;
                                r_state <= ST_CR_REQ;
                            end else begin
                                r_word  <= '0;
                                r_port  <= '0;
                                r_done  <= 1'b1;
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign wb_cyc_o    = w_cyc;
    assign wb_stb_o    = w_stb;
    assign wb_sel_o    = 4'b1111;
    assign cnt_dat_o   = r_cnt_dat;
    assign cnt_port_o  = r_port;
    assign cnt_word_o  = r_word;
    assign cnt_valid_o = r_valid;
    assign busy_o      = (r_state != ST_IDLE);
    assign done_o      = r_done;
    assign err_o       = r_err;

endmodule
